// File: rtl/pipeline_arbiter.sv
// pipeline_arbiter: N-way packet-aware round-robin arbiter feeding a single
// registered output slot. A requester that starts a multi-beat packet keeps
// the grant until it sends the beat marked i_last; the output slot gives one
// beat per cycle of throughput and one cycle of input-to-output latency.
module pipeline_arbiter #(
  parameter int N  = 4,
  parameter int DW = 256,
  parameter int IW = $clog2(N)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N-1:0]           i_valid,
  output logic [N-1:0]           i_ready,
  input  logic [N-1:0][DW-1:0]   i_data,
  input  logic [N-1:0]           i_last,
  output logic                   o_valid,
  input  logic                   o_ready,
  output logic [DW-1:0]          o_data,
  output logic                   o_last,
  output logic [IW-1:0]          o_id
);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  logic [0:0]    r_state;
  logic [IW-1:0] r_last;
  logic [IW-1:0] r_owner;
  logic          r_o_valid;
  logic [DW-1:0] r_o_data;
  logic          r_o_last;
  logic [IW-1:0] r_o_id;

  logic          w_slot_free;
  logic          w_found;
  logic          w_can_grant;
  logic          w_in_xfer;
  logic [IW-1:0] w_rr_pick;
  logic [IW-1:0] w_grant;

  // Round-robin search: first valid requester starting one past the last
  // channel that completed a packet, wrapping around.
  always_comb begin
    int c;
    w_rr_pick = '0;
    w_found   = 1'b0;
    c         = 0;
    for (int d = 1; d <= N; d++) begin
      c = (int'(r_last) + d) % N;
      if (!w_found && i_valid[IW'(c)]) begin
        w_found   = 1'b1;
        w_rr_pick = IW'(c);
      end
    end
  end

  // Grant selection and ready generation; a locked owner keeps the grant
  // even while its own valid is low, so no other channel can slip in.
  always_comb begin
    w_slot_free = !r_o_valid || o_ready;
    if (r_state == ST_LOCKED) begin
      w_grant     = r_owner;
      w_can_grant = 1'b1;
    end else begin
      w_grant     = w_rr_pick;
      w_can_grant = w_found;
    end
    i_ready = '0;
    if (!rst && w_slot_free && w_can_grant) begin
      i_ready[w_grant] = 1'b1;
    end
    w_in_xfer = !rst && w_slot_free && w_can_grant && i_valid[w_grant];
  end

  // Packet-lock FSM and round-robin pointer; only a completed packet moves
  // the pointer, so a lock does not skew fairness.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_last  <= IW'(N - 1);
      r_owner <= '0;
    end else if (w_in_xfer) begin
      if (i_last[w_grant]) begin
        r_state <= ST_IDLE;
        r_last  <= w_grant;
      end else if (r_state == ST_IDLE) begin
        r_state <= ST_LOCKED;
        r_owner <= w_grant;
      end
    end
  end

  // Output slot: load on input transfer (also when draining the same cycle),
  // empty on an output transfer with nothing new arriving, else hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_o_valid <= 1'b0;
      r_o_data  <= '0;
      r_o_last  <= 1'b0;
      r_o_id    <= '0;
    end else if (w_in_xfer) begin
      r_o_valid <= 1'b1;
      r_o_data  <= i_data[w_grant];
      r_o_last  <= i_last[w_grant];
      r_o_id    <= w_grant;
    end else if (o_ready) begin
      r_o_valid <= 1'b0;
    end
  end

  assign o_valid = r_o_valid;
  assign o_data  = r_o_data;
  assign o_last  = r_o_last;
  assign o_id    = r_o_id;

endmodule

// File: tb/tb_pipeline_arbiter.sv
// Testbench for pipeline_arbiter: per-channel packet sources, a transaction
// level reference model that predicts accepted beats into a scoreboard queue,
// and an independent monitor that pops and compares every output transfer.
module tb_pipeline_arbiter;

  localparam int N  = 4;
  localparam int DW = 256;
  localparam int IW = 2;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          l;
    logic [IW-1:0] id;
  } beat_t;

  logic                 clk;
  logic                 rst;
  logic [N-1:0]         i_valid;
  logic [N-1:0]         i_ready;
  logic [N-1:0][DW-1:0] i_data;
  logic [N-1:0]         i_last;
  logic                 o_valid;
  logic                 o_ready;
  logic [DW-1:0]        o_data;
  logic                 o_last;
  logic [IW-1:0]        o_id;

  pipeline_arbiter #(.N(N), .DW(DW), .IW(IW)) dut (
    .clk(clk), .rst(rst),
    .i_valid(i_valid), .i_ready(i_ready), .i_data(i_data), .i_last(i_last),
    .o_valid(o_valid), .o_ready(o_ready), .o_data(o_data), .o_last(o_last),
    .o_id(o_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // sources
  int            src_rem    [N];
  int            src_refill [N];
  bit            src_drop   [N];
  logic [DW-1:0] src_data   [N];
  bit            rand_mode = 0;
  logic [N-1:0]  acc;

  // reference model state
  beat_t sb[$];
  bit    m_val    = 0;
  bit    m_locked = 0;
  int    m_owner  = 0;
  int    m_last   = N - 1;
  int    m_g;
  bit    m_found, m_free;
  logic [N-1:0] m_rdy;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd();
    logic [DW-1:0] v;
    for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic apply();
    for (int k = 0; k < N; k++) begin
      i_valid[k] = (src_rem[k] != 0) && !src_drop[k];
      i_last[k]  = (src_rem[k] == 1);
      i_data[k]  = src_data[k];
    end
  endtask

  // One clock: drive, note handshakes mid-cycle, advance sources after edge.
  task automatic cyc();
    apply();
    @(negedge clk);
    acc = i_valid & i_ready;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (acc[k]) begin
        src_rem[k]--;
        src_data[k] = rnd();
        if (src_rem[k] == 0 && src_refill[k] != 0) src_rem[k] = src_refill[k];
      end
      if (rand_mode) begin
        if (src_rem[k] == 0 && ($urandom % 3) == 0) src_rem[k] = $urandom_range(1, 4);
        src_drop[k] = (($urandom % 6) == 0);
      end
    end
    if (rand_mode) begin
      o_ready = (($urandom % 4) != 0);
      rst     = (($urandom % 200) == 0);
    end
    apply();
  endtask

  task automatic drain();
    bit done;
    done = 0;
    o_ready = 1'b1;
    for (int k = 0; k < N; k++) begin
      src_refill[k] = 0;
      src_drop[k]   = 0;
    end
    for (int i = 0; i < 200 && !done; i++) begin
      cyc();
      done = (sb.size() == 0) && !o_valid;
      for (int k = 0; k < N; k++) if (src_rem[k] != 0) done = 0;
    end
    if (!done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: got pending beats expected none after 200 cycles");
    end
  endtask

  // Reference model: decides from the arbitration rules which beat (if any)
  // is accepted at the coming edge and queues it as the expected output.
  always @(negedge clk) begin
    check("o_valid", DW'(o_valid), DW'(m_val));
    if (rst) begin
      check("ready_in_reset", DW'(i_ready), '0);
      m_locked = 0;
      m_owner  = 0;
      m_last   = N - 1;
      m_val    = 0;
      sb.delete();
    end else begin
      m_free  = !m_val || o_ready;
      m_found = 0;
      m_g     = 0;
      if (m_locked) begin
        m_g     = m_owner;
        m_found = 1;
      end else begin
        for (int d = 1; d <= N; d++) begin
          if (!m_found && i_valid[(m_last + d) % N]) begin
            m_found = 1;
            m_g     = (m_last + d) % N;
          end
        end
      end
      m_rdy = '0;
      if (m_free && m_found) m_rdy[m_g] = 1'b1;
      check("i_ready", DW'(i_ready), DW'(m_rdy));
      if (m_free && m_found && i_valid[m_g]) begin
        beat_t b;
        b.d  = i_data[m_g];
        b.l  = i_last[m_g];
        b.id = IW'(m_g);
        sb.push_back(b);
        m_val = 1;
        if (i_last[m_g]) begin
          m_locked = 0;
          m_last   = m_g;
        end else if (!m_locked) begin
          m_locked = 1;
          m_owner  = m_g;
        end
      end else if (o_ready) begin
        m_val = 0;
      end
    end
  end

  // Monitor: every output transfer must match the oldest expected beat.
  always @(negedge clk) begin
    if (!rst && o_valid && o_ready) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL sb_unexpected: got beat id %0d expected no beat", o_id);
      end else begin
        beat_t e;
        e = sb.pop_front();
        check("out_data", o_data, e.d);
        check("out_last", DW'(o_last), DW'(e.l));
        check("out_id", DW'(o_id), DW'(e.id));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    o_ready = 1'b0;
    for (int k = 0; k < N; k++) begin
      src_rem[k] = 0; src_refill[k] = 0; src_drop[k] = 0; src_data[k] = rnd();
    end
    apply();
    repeat (2) @(posedge clk);
    #1;
    check("rst_o_valid", DW'(o_valid), '0);
    check("rst_o_data", o_data, '0);
    check("rst_o_last", DW'(o_last), '0);
    check("rst_o_id", DW'(o_id), '0);
    rst = 1'b0;

    // all valid, single-beat packets: ids rotate from channel 0
    for (int k = 0; k < N; k++) begin src_rem[k] = 1; src_refill[k] = 1; end
    o_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      check("rr_id", DW'(o_id), DW'(i % 4));
      check("rr_valid", DW'(o_valid), DW'(1));
    end
    drain();

    // ch1 3-beat packet holds off continuously valid ch2
    src_rem[1] = 3;
    src_rem[2] = 1; src_refill[2] = 1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      check("lock_id", DW'(o_id), DW'((i < 3) ? 1 : 2));
    end
    drain();

    // backpressure: 0xA5 from ch0 held 5 cycles, ch1 waits
    src_data[0] = DW'(8'hA5);
    src_rem[0] = 1;
    src_rem[1] = 1;
    o_ready = 1'b0;
    cyc();
    check("stall_data", o_data, DW'(8'hA5));
    for (int i = 0; i < 5; i++) begin
      cyc();
      check("stall_data", o_data, DW'(8'hA5));
      check("stall_id", DW'(o_id), '0);
      check("stall_ready", DW'(i_ready), '0);
    end
    o_ready = 1'b1;
    cyc();
    check("stall_next_id", DW'(o_id), DW'(1));
    drain();

    // owner ch3 drops valid mid-packet; ch0 must not get in
    src_rem[3] = 3;
    cyc();
    check("own_first", DW'(o_id), DW'(3));
    src_drop[3] = 1;
    src_rem[0] = 1; src_refill[0] = 1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      check("own_gap_valid", DW'(o_valid), '0);
    end
    src_drop[3] = 0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("own_resume_id", DW'(o_id), DW'((i < 2) ? 3 : 0));
    end
    drain();

    // reset mid-packet, then ch0 wins over ch2
    src_rem[2] = 4;
    cyc();
    check("rstmid_first", DW'(o_id), DW'(2));
    rst = 1'b1;
    src_rem[0] = 1;
    cyc();
    check("rstmid_o_valid", DW'(o_valid), '0);
    cyc();
    check("rstmid_id", DW'(o_id), '0);
    check("rstmid_valid", DW'(o_valid), DW'(1));
    drain();

    // single requester at full rate
    src_rem[2] = 1; src_refill[2] = 1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("solo_id", DW'(o_id), DW'(2));
      check("solo_valid", DW'(o_valid), DW'(1));
    end
    drain();

    // randomized traffic with backpressure, valid drops and rare resets
    rand_mode = 1;
    repeat (3000) cyc();
    rand_mode = 0;
    rst = 1'b0;
    drain();
    check("sb_drained", DW'(sb.size()), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pipeline_arbiter.md
PIPELINE_ARBITER -- requirements
Module: pipeline_arbiter

Parameters
REQ-001 N, default 4: number of requester channels, N >= 2.
REQ-002 DW, default 256: payload width in bits.
REQ-003 IW, default $clog2(N): width of the source-index field.

Interface
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 i_valid  input  1 [N]  per-requester valid.
REQ-007 i_ready  output  1 [N]  per-requester ready.
REQ-008 i_data  input  DW [N]  per-requester payload.
REQ-009 i_last  input  1 [N]  marks the final beat of a requester's packet.
REQ-010 o_valid  output  1  registered output valid.
REQ-011 o_ready  input  1  downstream ready.
REQ-012 o_data  output  DW  registered payload.
REQ-013 o_last  output  1  registered copy of the accepted i_last.
REQ-014 o_id  output  IW  index of the requester that produced the current output beat.

Function
REQ-015 The output stage SHALL be a single register slot; slot_free = !o_valid || o_ready, evaluated in the same cycle.
REQ-016 An input transfer on channel k SHALL occur when i_valid[k] && i_ready[k]; an output transfer SHALL occur when o_valid && o_ready.
REQ-017 At most one i_ready bit SHALL be high per cycle: i_ready[k] = slot_free && (k == grant); i_ready SHALL NOT depend on i_valid of other channels while LOCKED.
REQ-018 FSM states SHALL be IDLE (no packet in progress) and LOCKED (packet from owner in progress).
REQ-019 In IDLE, grant SHALL be the first k with i_valid[k]=1, searching from (last+1) mod N upward with wrap. Here last is the most recently granted channel.
REQ-020 In LOCKED, grant SHALL equal owner regardless of other valids; other channels SHALL see i_ready=0.
REQ-021 On an input transfer in IDLE with i_last=0, the FSM SHALL go to LOCKED, with owner := grant.
REQ-022 On an input transfer with i_last=1, in either state, the FSM SHALL go to or stay in IDLE.
REQ-023 On every input transfer that ends a packet (i_last=1), last SHALL be set to the transferring channel. The next arbitration SHALL therefore start one past it.
REQ-024 A single-beat packet (i_last=1 on the first beat) SHALL NOT enter LOCKED.
REQ-025 On an input transfer, o_data, o_last and o_id SHALL load i_data[grant], i_last[grant] and grant on the next edge, and o_valid SHALL be set to 1.
REQ-026 On an output transfer with no input transfer in the same cycle, o_valid SHALL clear to 0.
REQ-027 A simultaneous output and input transfer SHALL replace the slot contents, giving full throughput of 1 beat per cycle.
REQ-028 While o_valid && !o_ready, o_data, o_last and o_id SHALL hold stable and all i_ready SHALL be 0.
REQ-029 Input-to-output latency SHALL be 1 cycle: a beat accepted at edge t is visible on o_* after edge t.
REQ-030 If no i_valid is set in IDLE, grant SHALL be don't-care, no transfer SHALL occur, and last and state SHALL be unchanged.
REQ-031 An owner that deasserts i_valid mid-packet SHALL keep the lock; the block SHALL stay LOCKED indefinitely until that owner completes the packet with i_last.

Reset
REQ-032 When rst=1 at a rising edge: state := IDLE, last := N-1 (channel 0 highest priority first), owner := 0, o_valid := 0, o_data := 0, o_last := 0, o_id := 0.
REQ-033 While rst=1, all i_ready SHALL be 0.
REQ-034 Reset asserted mid-packet SHALL discard the packet and output slot content without emitting further beats.

Verification
REQ-035 After reset, i_valid=4'b1111, all i_last=1, o_ready=1 -> o_id sequence 0,1,2,3,0, with one beat per cycle and o_valid continuous from cycle 1.
REQ-036 Ch1 sends a 3-beat packet (i_last on beat 3) while ch2 is continuously valid, o_ready=1 -> o_id = 1,1,1,2 in consecutive cycles; i_ready[2]=0 during ch1's beats 1-3.
REQ-037 Beat 0xA5 from ch0 is accepted with o_ready held 0 for 5 cycles -> o_data=0xA5 and o_id=0 are stable, and all i_ready=0, for those 5 cycles; the next beat is accepted the cycle o_ready rises.
REQ-038 Owner ch3 mid-packet drops i_valid for 4 cycles while ch0 is valid -> no ch0 beat is emitted; ch3's remaining beats follow, then ch0.
REQ-039 rst pulsed for 1 cycle during ch2's 2nd of 4 beats -> next cycle o_valid=0 and state IDLE; with ch2 and ch0 both valid afterwards, ch0 is granted first.
REQ-040 Only ch2 is valid with o_ready=1, single-beat packets, for 3 cycles -> o_id=2 on each cycle, and throughput is 1 beat per cycle.
